// File: rtl/hazard_ctl.sv
// hazard_ctl: load-use / mul-div interlock and mul/div busy counter for mips789.
// pause and id_bubble are combinational from the inputs and the counter; the
// counter, md_done and md_err are registered.
module hazard_ctl #(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 33,
    parameter int unsigned CW         = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic       id_md_rd,
    input  logic       id_md_start,
    input  logic       ex_load,
    input  logic       ex_we,
    input  logic [4:0] ex_wr_rn,
    input  logic       ex_md_start,
    input  logic       ex_md_div,
    input  logic       md_abort,
    input  logic       ext_hold,
    output logic       pause,
    output logic       id_bubble,
    output logic       md_busy,
    output logic       md_done,
    output logic       md_err
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          lu_hz;
    logic          md_hz;
    logic [CW-1:0] load_cnt;

    // Load in EX whose destination is a live source operand of ID.
    always_comb begin
        lu_hz = 1'b0;
        if (ex_load && ex_we && (ex_wr_rn != 5'd0)) begin
            lu_hz = (id_use_rs && (ex_wr_rn == id_rs)) ||
                    (id_use_rt && (ex_wr_rn == id_rt));
        end
    end

    assign md_busy   = (cnt_q != '0);
    assign md_hz     = md_busy & (id_md_rd | id_md_start);
    assign pause     = lu_hz | md_hz | ext_hold;
    assign id_bubble = (lu_hz | md_hz) & ~ext_hold;
    assign md_done   = done_q;
    assign md_err    = err_q;
    assign load_cnt  = ex_md_div ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);

    // Mul/div occupancy: next state, count, completion pulse and sticky error.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = err_q;
        if (md_abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ex_md_start) begin
                        state_d = S_BUSY;
                        cnt_d   = load_cnt;
                    end
                end
                S_BUSY: begin
                    if (cnt_q == CW'(1)) begin
                        done_d = 1'b1;
                        if (ex_md_start) begin
                            cnt_d = load_cnt;
                        end else begin
                            state_d = S_IDLE;
                            cnt_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                        if (ex_md_start) begin
                            err_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctl.sv
// Bench for hazard_ctl: directed scenarios with literal expectations, then
// random stimulus checked each cycle against a cycle-index model.
module tb_hazard_ctl;

    localparam int unsigned MUL_N = 4;
    localparam int unsigned DIV_N = 33;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_wr_rn;
    logic       id_use_rs, id_use_rt, id_md_rd, id_md_start;
    logic       ex_load, ex_we, ex_md_start, ex_md_div, md_abort, ext_hold;
    logic       pause, id_bubble, md_busy, md_done, md_err;

    int n_tests = 0;
    int n_fail  = 0;

    hazard_ctl #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N), .CW(6)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_md_rd(id_md_rd), .id_md_start(id_md_start),
        .ex_load(ex_load), .ex_we(ex_we), .ex_wr_rn(ex_wr_rn),
        .ex_md_start(ex_md_start), .ex_md_div(ex_md_div),
        .md_abort(md_abort), .ext_hold(ext_hold),
        .pause(pause), .id_bubble(id_bubble),
        .md_busy(md_busy), .md_done(md_done), .md_err(md_err)
    );

    always #5 clk = ~clk;

    // Model: the unit is busy in every cycle whose index is <= busy_end.
    longint cyc      = 0;
    longint busy_end = -1;
    logic   m_done   = 1'b0;
    logic   m_err    = 1'b0;
    logic   cmp_en   = 1'b0;

    always @(posedge clk) begin
        if (!rst) begin
            busy_end <= -1;
            m_done   <= 1'b0;
            m_err    <= 1'b0;
        end else begin
            m_done <= !md_abort && (cyc <= busy_end) && (busy_end == cyc);
            if (md_abort) begin
                busy_end <= cyc;
            end else if (ex_md_start) begin
                if (cyc >= busy_end)
                    busy_end <= cyc + longint'(ex_md_div ? DIV_N : MUL_N);
                else
                    m_err <= 1'b1;
            end
        end
        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            logic lu, mb, mh;
            lu = ex_load && ex_we && (ex_wr_rn != 5'd0) &&
                 ((id_use_rs && ex_wr_rn == id_rs) || (id_use_rt && ex_wr_rn == id_rt));
            mb = (cyc <= busy_end);
            mh = mb && (id_md_rd || id_md_start);
            chk("pause",     pause,     lu || mh || ext_hold);
            chk("id_bubble", id_bubble, (lu || mh) && !ext_hold);
            chk("md_busy",   md_busy,   mb);
            chk("md_done",   md_done,   m_done);
            chk("md_err",    md_err,    m_err);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic idle_inputs();
        id_rs = 5'd0; id_rt = 5'd0; ex_wr_rn = 5'd0;
        id_use_rs = 1'b0; id_use_rt = 1'b0; id_md_rd = 1'b0; id_md_start = 1'b0;
        ex_load = 1'b0; ex_we = 1'b0; ex_md_start = 1'b0; ex_md_div = 1'b0;
        md_abort = 1'b0; ext_hold = 1'b0;
    endtask

    // Issue a mul/div in the current cycle and advance into cycle T+1.
    task automatic issue(input logic div);
        ex_md_start = 1'b1; ex_md_div = div;
        tick();
        ex_md_start = 1'b0; ex_md_div = 1'b0;
    endtask

    initial begin
        int k;
        logic seen;
        idle_inputs();
        rst = 1'b0;
        ticks(2);
        rst = 1'b1;
        cmp_en = 1'b1;
        chk("rst_busy", md_busy, 1'b0);
        chk("rst_done", md_done, 1'b0);
        chk("rst_err",  md_err,  1'b0);

        // Load-use on rs.
        ex_load = 1'b1; ex_we = 1'b1; ex_wr_rn = 5'd5; id_rs = 5'd5; id_use_rs = 1'b1;
        #1;
        chk("lu_pause", pause, 1'b1);
        chk("lu_bubble", id_bubble, 1'b1);
        tick();
        ex_load = 1'b0; ex_we = 1'b0; #1;
        chk("lu_one_cycle", pause, 1'b0);
        ex_load = 1'b1; ex_we = 1'b1; ex_wr_rn = 5'd0; id_rs = 5'd0; #1;
        chk("lu_r0", pause, 1'b0);
        ex_wr_rn = 5'd5; id_rs = 5'd5; id_use_rs = 1'b0; #1;
        chk("lu_nouse", pause, 1'b0);
        id_rt = 5'd5; id_use_rt = 1'b1; ext_hold = 1'b1; #1;
        chk("hold_pause", pause, 1'b1);
        chk("hold_bubble", id_bubble, 1'b0);
        idle_inputs();
        tick();

        // MULT with MFLO waiting in ID.
        id_md_rd = 1'b1;
        issue(1'b0);
        for (int i = 1; i <= 5; i++) begin
            chk("mul_busy",  md_busy, (i <= 4));
            chk("mul_pause", pause,   (i <= 4));
            chk("mul_done",  md_done, (i == 5));
            tick();
        end
        id_md_rd = 1'b0;

        // DIV latency to md_done.
        issue(1'b1);
        k = 1;
        while (!md_done && k < 100) begin tick(); k++; end
        chk_int("div_done_latency", k, 34);
        tick();

        // Back-to-back MULT issued at cnt == 1.
        issue(1'b1);
        ticks(32);
        issue(1'b0);
        chk("b2b_done", md_done, 1'b1);
        chk("b2b_busy", md_busy, 1'b1);
        ticks(3);
        chk("b2b_busy_end", md_busy, 1'b1);
        tick();
        chk("b2b_idle", md_busy, 1'b0);
        chk("b2b_done2", md_done, 1'b1);
        tick();

        // Count continues under ext_hold.
        ext_hold = 1'b1;
        issue(1'b0);
        ticks(4);
        chk("hold_md_done", md_done, 1'b1);
        ext_hold = 1'b0;
        tick();

        // Abort at cnt == 10 of a divide.
        issue(1'b1);
        ticks(23);
        md_abort = 1'b1;
        tick();
        md_abort = 1'b0;
        chk("abort_busy", md_busy, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin seen |= md_done; tick(); end
        chk("abort_no_done", seen, 1'b0);

        // Illegal issue at cnt == 5 sets md_err; count unaffected.
        issue(1'b1);
        ticks(28);
        issue(1'b1);
        chk("err_set", md_err, 1'b1);
        chk("err_busy", md_busy, 1'b1);
        ticks(4);
        chk("err_done_time", md_done, 1'b1);
        tick();
        chk("err_sticky", md_err, 1'b1);

        // Synchronous reset mid-divide.
        issue(1'b1);
        ticks(10);
        rst = 1'b0; #1;
        chk("rst_pre_edge", md_busy, 1'b1);
        tick();
        rst = 1'b1;
        chk("rst_mid_busy", md_busy, 1'b0);
        chk("rst_mid_done", md_done, 1'b0);
        chk("rst_mid_err",  md_err,  1'b0);

        // Random phase.
        for (int i = 0; i < 4000; i++) begin
            id_rs       = 5'($urandom_range(0, 3));
            id_rt       = 5'($urandom_range(0, 3));
            ex_wr_rn    = 5'($urandom_range(0, 3));
            id_use_rs   = 1'($urandom_range(0, 1));
            id_use_rt   = 1'($urandom_range(0, 1));
            id_md_rd    = ($urandom_range(0, 3) == 0);
            id_md_start = ($urandom_range(0, 5) == 0);
            ex_load     = 1'($urandom_range(0, 1));
            ex_we       = ($urandom_range(0, 3) != 0);
            ex_md_start = ($urandom_range(0, 7) == 0);
            ex_md_div   = ($urandom_range(0, 3) == 0);
            md_abort    = ($urandom_range(0, 59) == 0);
            ext_hold    = ($urandom_range(0, 4) == 0);
            rst         = ($urandom_range(0, 299) != 0);
            tick();
        end
        rst = 1'b1;
        idle_inputs();
        tick();
        @(negedge clk);
        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
